// File: rtl/fifo_512x32p_pkg.sv
// Shared geometry and lane map for the 512x32 parity-protected FIFO.
package fifo_512x32p_pkg;

  localparam int unsigned Depth    = 512;
  localparam int unsigned PtrW     = 9;
  localparam int unsigned LevelW   = 10;
  localparam int unsigned LaneW    = 9;
  localparam int unsigned NumLanes = 4;
  localparam int unsigned DataW    = 32;
  localparam int unsigned MemW     = LaneW * NumLanes;

  typedef logic [MemW-1:0] mem_word_t;

  // Byte k occupies memory bits [9k+7:9k]; its parity bit sits at 9k+8.
  function automatic int unsigned lane_base(input int unsigned k);
    return k * LaneW;
  endfunction

  function automatic mem_word_t pack_word(input logic [DataW-1:0]    data,
                                          input logic [NumLanes-1:0] inject);
    mem_word_t w;
    w = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      w[lane_base(k) +: 8] = data[8*k +: 8];
      w[lane_base(k) + 8]  = (^data[8*k +: 8]) ^ inject[k];
    end
    return w;
  endfunction

  function automatic logic [DataW-1:0] unpack_data(input mem_word_t w);
    logic [DataW-1:0] d;
    d = '0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      d[8*k +: 8] = w[lane_base(k) +: 8];
    end
    return d;
  endfunction

  function automatic logic parity_bad(input mem_word_t w);
    logic bad;
    bad = 1'b0;
    for (int unsigned k = 0; k < NumLanes; k++) begin
      bad = bad | (^w[lane_base(k) +: LaneW]);
    end
    return bad;
  endfunction

endpackage

// File: rtl/fifo_512x32p_mem.sv
// 512x36 dual-port block memory with 9-bit byte lanes and registered port-1 read.
module xil_mem_dp_512x36
  import fifo_512x32p_pkg::*;
(
  input  logic                clk_i,
  input  logic                en0_i,
  input  logic [NumLanes-1:0] be0_i,
  input  logic [PtrW-1:0]     addr0_i,
  input  mem_word_t           wdata0_i,
  input  logic                en1_i,
  input  logic [NumLanes-1:0] be1_i,
  input  logic [PtrW-1:0]     addr1_i,
  input  mem_word_t           wdata1_i,
  output mem_word_t           rdata1_o
);

  mem_word_t mem_q [Depth];
  mem_word_t rdata_q;

  // Read-before-write on port 1; the storage array is intentionally not reset.
  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < NumLanes; k++) begin
      if (en0_i && be0_i[k]) begin
        mem_q[addr0_i][lane_base(k) +: LaneW] <= wdata0_i[lane_base(k) +: LaneW];
      end
      if (en1_i && be1_i[k]) begin
        mem_q[addr1_i][lane_base(k) +: LaneW] <= wdata1_i[lane_base(k) +: LaneW];
      end
    end
    if (en1_i) begin
      rdata_q <= mem_q[addr1_i];
    end
  end

  assign rdata1_o = rdata_q;

endmodule

// File: rtl/fifo_512x32p.sv
// Show-ahead 512x32 FIFO with per-byte even parity stored in a 512x36 block memory.
module fifo_512x32p
  import fifo_512x32p_pkg::*;
#(
  parameter int unsigned AFULL_THRESH = 448
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_wr_valid,
  input  logic [31:0]       i_wr_data,
  input  logic [3:0]        i_par_inject,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [31:0]       o_rd_data,
  input  logic              i_rd_ready,
  output logic [9:0]        o_level,
  output logic              o_almost_full,
  output logic              o_par_err
);

  localparam logic [LevelW-1:0] FullLevel  = LevelW'(Depth);
  localparam logic [LevelW-1:0] AfullLevel = LevelW'(AFULL_THRESH);

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LevelW-1:0] level_q, level_d;
  logic              rd_valid_q, rd_valid_d;
  logic              par_err_q, par_err_d;

  logic      wr_hs, pop, pending, issue;
  mem_word_t wr_word, rd_word;

  assign o_wr_ready = rst_n && (level_q < FullLevel) && !i_flush;
  assign wr_hs      = i_wr_valid && o_wr_ready;
  assign pop        = rd_valid_q && i_rd_ready;
  // Words in the FIFO minus the one (if any) already presented on the read port.
  assign pending    = (level_q != LevelW'(rd_valid_q));
  assign issue      = pending && (!rd_valid_q || i_rd_ready) && !i_flush;
  assign wr_word    = pack_word(i_wr_data, i_par_inject);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    rd_valid_d = rd_valid_q;
    par_err_d  = pop && parity_bad(rd_word);
    if (i_flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (wr_hs) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (issue) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      if (wr_hs && !pop) begin
        level_d = level_q + LevelW'(1);
      end else if (pop && !wr_hs) begin
        level_d = level_q - LevelW'(1);
      end
      if (issue) begin
        rd_valid_d = 1'b1;
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
      par_err_q  <= par_err_d;
    end
  end

  xil_mem_dp_512x36 u_mem (
    .clk_i    (clk),
    .en0_i    (wr_hs),
    .be0_i    ({NumLanes{wr_hs}}),
    .addr0_i  (wr_ptr_q),
    .wdata0_i (wr_word),
    .en1_i    (issue),
    .be1_i    ('0),
    .addr1_i  (rd_ptr_q),
    .wdata1_i ('0),
    .rdata1_o (rd_word)
  );

  assign o_rd_data     = unpack_data(rd_word);
  assign o_rd_valid    = rd_valid_q;
  assign o_level       = level_q;
  assign o_almost_full = (level_q >= AfullLevel);
  assign o_par_err     = par_err_q;

endmodule

// File: tb/tb_fifo_512x32p.sv
// Self-checking bench for fifo_512x32p: cycle table, directed corners, random traffic vs a queue.
module tb_fifo_512x32p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_flush = 1'b0;
  logic        i_wr_valid = 1'b0;
  logic [31:0] i_wr_data = '0;
  logic [3:0]  i_par_inject = '0;
  logic        i_rd_ready = 1'b0;
  logic        o_wr_ready, o_rd_valid, o_almost_full, o_par_err;
  logic [31:0] o_rd_data;
  logic [9:0]  o_level;

  fifo_512x32p #(.AFULL_THRESH(448)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .i_wr_valid    (i_wr_valid),
    .i_wr_data     (i_wr_data),
    .i_par_inject  (i_par_inject),
    .o_wr_ready    (o_wr_ready),
    .o_rd_valid    (o_rd_valid),
    .o_rd_data     (o_rd_data),
    .i_rd_ready    (i_rd_ready),
    .o_level       (o_level),
    .o_almost_full (o_almost_full),
    .o_par_err     (o_par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  inj;
  } item_t;

  typedef struct {
    logic        wv;
    logic [31:0] wd;
    logic [3:0]  inj;
    logic        rr;
    logic [9:0]  lvl;
    logic        rv;
    logic [31:0] rd;
    logic        pe;
  } vec_t;

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    stall   = 0;
  bit    pe_exp  = 1'b0;
  vec_t  vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called at the falling edge: compare outputs to the model, then advance it at the rising edge.
  task automatic finish_cycle();
    bit ready_exp, wr_hs, pop, pe_next;
    int sz;
    sz = q.size();
    chk("level", o_level, sz);
    ready_exp = (sz < 512) && !i_flush;
    chk("wr_ready", o_wr_ready, ready_exp);
    chk("almost_full", o_almost_full, sz >= 448);
    chk("par_err", o_par_err, pe_exp);
    chk("rd_valid_empty", o_rd_valid && (sz == 0), 0);
    if (o_rd_valid && sz != 0) chk("rd_data", o_rd_data, q[0].d);
    stall = (sz != 0 && !o_rd_valid) ? stall + 1 : 0;
    chk("rd_latency", stall > 2, 0);
    wr_hs = i_wr_valid && ready_exp;
    pop = o_rd_valid && i_rd_ready;
    pe_next = 1'b0;
    if (pop && sz != 0) pe_next = (q[0].inj != 4'd0);
    @(posedge clk);
    if (i_flush) begin
      q.delete();
    end else begin
      if (pop && sz != 0) q.delete(0);
      if (wr_hs) q.push_back('{d: i_wr_data, inj: i_par_inject});
    end
    pe_exp = pe_next;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic drive(input logic wv, input logic [31:0] wd, input logic [3:0] inj,
                       input logic rr, input logic fl);
    i_wr_valid = wv;
    i_wr_data = wd;
    i_par_inject = inj;
    i_rd_ready = rr;
    i_flush = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_level", o_level, 0);
    chk("rst_rd_valid", o_rd_valid, 0);
    chk("rst_wr_ready", o_wr_ready, 0);
    chk("rst_almost_full", o_almost_full, 0);
    chk("rst_par_err", o_par_err, 0);
    q.delete();
    pe_exp = 1'b0;
    stall = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 1200 && (q.size() != 0 || o_rd_valid); i++) tick();
    tick();
    chk("drain_level", o_level, 0);
    chk("drain_rd_valid", o_rd_valid, 0);
  endtask

  // Random traffic biased towards writes until the model holds 37 words.
  task automatic fill_to_37();
    for (int i = 0; i < 500 && q.size() != 37; i++) begin
      drive(1'b1, $urandom, '0, ($urandom % 4) == 0 && q.size() < 37, 1'b0);
      if (q.size() > 37) i_wr_valid = 1'b0;
      tick();
    end
    chk("reach_37", o_level, 37);
  endtask

  initial begin
    #1;
    do_reset();

    vecs[0] = '{1'b1, 32'h11223344, 4'b0000, 1'b1, 10'd0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0,        4'b0000, 1'b1, 10'd1, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'h0,        4'b0000, 1'b1, 10'd1, 1'b1, 32'h11223344, 1'b0};
    vecs[3] = '{1'b1, 32'hAABBCCDD, 4'b0100, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0};
    vecs[4] = '{1'b1, 32'h55667788, 4'b0000, 1'b0, 10'd1, 1'b0, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 32'h0,        4'b0000, 1'b0, 10'd2, 1'b1, 32'hAABBCCDD, 1'b0};
    vecs[6] = '{1'b0, 32'h0,        4'b0000, 1'b1, 10'd2, 1'b1, 32'hAABBCCDD, 1'b0};
    vecs[7] = '{1'b0, 32'h0,        4'b0000, 1'b1, 10'd1, 1'b1, 32'h55667788, 1'b1};
    vecs[8] = '{1'b0, 32'h0,        4'b0000, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0};
    vecs[9] = '{1'b0, 32'h0,        4'b0000, 1'b0, 10'd0, 1'b0, 32'h0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].wv, vecs[i].wd, vecs[i].inj, vecs[i].rr, 1'b0);
      @(negedge clk);
      chk($sformatf("vec%0d_level", i), o_level, vecs[i].lvl);
      chk($sformatf("vec%0d_rd_valid", i), o_rd_valid, vecs[i].rv);
      if (vecs[i].rv) chk($sformatf("vec%0d_rd_data", i), o_rd_data, vecs[i].rd);
      chk($sformatf("vec%0d_par_err", i), o_par_err, vecs[i].pe);
      finish_cycle();
    end

    // Fill to capacity with no reads, then attempt one extra write.
    for (int i = 1; i <= 512; i++) begin
      drive(1'b1, $urandom, '0, 1'b0, 1'b0);
      tick();
      if (i == 447) chk("afull_before_448", o_almost_full, 0);
      if (i == 448) chk("afull_at_448", o_almost_full, 1);
    end
    chk("full_level", o_level, 512);
    chk("full_wr_ready", o_wr_ready, 0);
    drive(1'b1, 32'hDEADBEEF, '0, 1'b0, 1'b0);
    tick();
    chk("full_513th_level", o_level, 512);

    // Concurrent write and pop from full, data order checked across pointer wrap.
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, $urandom, '0, 1'b1, 1'b0);
      tick();
    end
    drain();

    // Consumer stall with a valid head word.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hA5000000 + i, '0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_hold", o_rd_data, 32'hA5000000);
      chk("stall_valid", o_rd_valid, 1);
    end
    drain();

    // Flush at level 37 during traffic.
    fill_to_37();
    drive(1'b1, 32'h0BADF00D, '0, 1'b1, 1'b1);
    tick();
    chk("flush_level", o_level, 0);
    chk("flush_rd_valid", o_rd_valid, 0);
    drive(1'b1, 32'hCAFE0001, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("flush_next_word", o_rd_data, 32'hCAFE0001);
    drain();

    // Asynchronous reset at level 37 during traffic.
    fill_to_37();
    drive(1'b1, $urandom, '0, 1'b1, 1'b0);
    do_reset();
    drive(1'b1, 32'hCAFE0002, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("reset_next_word", o_rd_data, 32'hCAFE0002);
    drain();

    // Random traffic with occasional parity injection and flush.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 4) != 0, $urandom, (($urandom % 8) == 0) ? 4'($urandom) : 4'd0,
            ($urandom % 3) != 0, ($urandom % 200) == 0);
      tick();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
